// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC sequencer: the FSM state type and the
// accumulator width helper that the sibling MAC also uses for its sizing.
package mac_seq_pkg;

   // Sequencer phases: clear the MAC, stream operands, let the last product
   // land, then hold the captured sum until it is accepted.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } mac_seq_state_t;

   // Accumulator width: a full product plus DATA_WIDTH bits of growth headroom.
   function automatic int acc_w(input int data_width);
      return 3 * data_width;
   endfunction

endpackage

// File: rtl/mac_seq.sv
// mac_seq: initiator for one MAC accumulator. A start command clears the MAC,
// pops len operand pairs jointly from the A/B streams onto the MAC enable and
// operand inputs, then presents the accumulated sum on a valid/ready port.
// Optional build macro MAC_SEQ_STALL_CNT_EN adds a saturating counter of RUN
// cycles in which no operand pair fired; without it stall_cnt is tied to 0.
module mac_seq
   import mac_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = 8,
   parameter int STALL_W    = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [LEN_W-1:0]                len,
   output logic                            busy,
   input  logic [DATA_WIDTH-1:0]           a_data,
   input  logic [DATA_WIDTH-1:0]           b_data,
   input  logic                            a_valid,
   input  logic                            b_valid,
   output logic                            a_ready,
   output logic                            b_ready,
   output logic                            mac_en,
   output logic                            mac_clr,
   output logic [DATA_WIDTH-1:0]           mac_a,
   output logic [DATA_WIDTH-1:0]           mac_b,
   input  logic [acc_w(DATA_WIDTH)-1:0]    mac_cout,
   output logic [acc_w(DATA_WIDTH)-1:0]    res_data,
   output logic                            res_valid,
   input  logic                            res_ready,
   output logic [STALL_W-1:0]              stall_cnt
);

   mac_seq_state_t   state_q;
   logic [LEN_W-1:0] remaining_q;
   logic             fire;

   // Combinational handshakes and MAC drive; everything idles at 0 outside RUN
   // so the MAC and the operand FIFOs only ever see joint pops.
   always_comb begin
      fire      = 1'b0;
      busy      = (state_q != ST_IDLE);
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      mac_en    = 1'b0;
      mac_clr   = (state_q == ST_CLEAR);
      mac_a     = '0;
      mac_b     = '0;
      res_valid = (state_q == ST_DONE);
      if (state_q == ST_RUN) begin
         fire    = a_valid & b_valid;
         a_ready = fire;
         b_ready = fire;
         mac_en  = fire;
         mac_a   = a_data;
         mac_b   = b_data;
      end
   end

   // Job sequencing: remaining counts pairs still to pop; the final fire moves
   // to DRAIN so the MAC's registered sum includes the last product.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  remaining_q <= len;
                  state_q     <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               state_q <= (remaining_q == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
               if (fire) begin
                  remaining_q <= remaining_q - LEN_W'(1);
                  if (remaining_q == LEN_W'(1)) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               if (res_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Result capture at the end of DRAIN; held unchanged through DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_data <= '0;
      end else if (state_q == ST_DRAIN) begin
         res_data <= mac_cout;
      end
   end

`ifdef MAC_SEQ_STALL_CNT_EN
   logic [STALL_W-1:0] stall_q;

   // Stall statistics: restart on an accepted start, count starved RUN cycles,
   // saturate at all-ones, and hold the final figure until the next job.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if ((state_q == ST_IDLE) && start) begin
         stall_q <= '0;
      end else if ((state_q == ST_RUN) && !fire && (stall_q != '1)) begin
         stall_q <= stall_q + STALL_W'(1);
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// Testbench for mac_seq paired with a behavioural MAC. Jobs are issued by a
// driver task that pushes the expected sum, pop count, stall count and
// latency into a scoreboard; a negedge monitor pops and compares whenever the
// result handshake completes.
module tb_mac_seq;

   localparam int DW = 8;
   localparam int LW = 8;
   localparam int SW = 16;
   localparam int AW = 3 * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          busy;
   logic [DW-1:0] a_data, b_data;
   logic          a_valid, b_valid;
   logic          a_ready, b_ready;
   logic          mac_en, mac_clr;
   logic [DW-1:0] mac_a, mac_b;
   logic [AW-1:0] mac_cout;
   logic [AW-1:0] res_data;
   logic          res_valid;
   logic          res_ready;
   logic [SW-1:0] stall_cnt;

   typedef struct {
      logic [AW-1:0] res;
      int            stall;
      int            pops;
      int            pop_base;
      int            start_cyc;
      int            lat;
   } exp_t;

   exp_t          exp_q[$];
   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            total_pops = 0;
   int            proto_err = 0;
   int            valid_cyc = 0;
   bit            seen_valid = 0;
   logic [DW-1:0] job_a [256];
   logic [DW-1:0] job_b [256];
   int            stall_before [256];

   always #5 clk = ~clk;

   mac_seq #(.DATA_WIDTH(DW), .LEN_W(LW), .STALL_W(SW)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
      .a_data(a_data), .b_data(b_data), .a_valid(a_valid), .b_valid(b_valid),
      .a_ready(a_ready), .b_ready(b_ready), .mac_en(mac_en), .mac_clr(mac_clr),
      .mac_a(mac_a), .mac_b(mac_b), .mac_cout(mac_cout), .res_data(res_data),
      .res_valid(res_valid), .res_ready(res_ready), .stall_cnt(stall_cnt)
   );

   // Sibling MAC: clear, or accumulate the product one cycle after enable.
   always_ff @(posedge clk) begin
      if (rst || mac_clr) mac_cout <= '0;
      else if (mac_en) mac_cout <= mac_cout + AW'(mac_a) * AW'(mac_b);
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (a_ready && a_valid) total_pops <= total_pops + 1;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Scoreboard monitor: protocol watch every cycle, result compare on handshake.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         seen_valid = 0;
      end else begin
         if ((a_ready !== b_ready) || (a_ready && !(a_valid && b_valid))) proto_err++;
         if (res_valid && !seen_valid) begin
            seen_valid = 1;
            valid_cyc  = cyc;
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_result", 64'(res_data), 64'(0) - 1);
            end else begin
               e = exp_q.pop_front();
               checkOutput("res_data", 64'(res_data), 64'(e.res));
               checkOutput("stall_cnt", 64'(stall_cnt), 64'(e.stall));
               checkOutput("pops", 64'(total_pops - e.pop_base), 64'(e.pops));
               checkOutput("latency", 64'(valid_cyc - e.start_cyc), 64'(e.lat));
            end
            seen_valid = 0;
         end
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, 64'(busy), 0);
      checkOutput({tag, "_ready"}, 64'({a_ready, b_ready}), 0);
      checkOutput({tag, "_mac_ctl"}, 64'({mac_en, mac_clr}), 0);
      checkOutput({tag, "_mac_ops"}, 64'({mac_a, mac_b}), 0);
      checkOutput({tag, "_res_data"}, 64'(res_data), 0);
      checkOutput({tag, "_res_valid"}, 64'(res_valid), 0);
      checkOutput({tag, "_stall_cnt"}, 64'(stall_cnt), 0);
   endtask

   // One job: mode 0 no stalls, 1 three b_valid drops before pair 2,
   // 2 random drops of 0..2 cycles before each later pair.
   task automatic applyStimulus(input int n, input int mode, input int ready_delay,
                                input bit start_in_wait, input int abort_at);
      exp_t          e;
      logic [AW-1:0] sum = '0;
      int            stalls = 0;
      int            idx = 0;
      int            hold_left = 0;
      int            guard = 0;
      int            budget;
      bit            fired, done;
      for (int i = 0; i < 256; i++) begin
         stall_before[i] = 0;
         if (mode == 2 && i >= 1 && i < n) stall_before[i] = $urandom_range(2);
      end
      if (mode == 1) stall_before[2] = 3;
      for (int i = 0; i < n; i++) begin
         sum    = sum + AW'(job_a[i]) * AW'(job_b[i]);
         stalls = stalls + stall_before[i];
      end
      budget = n + stalls + 20;
      @(posedge clk); #1;
      start = 1'b1;
      len   = LW'(n);
      e.res       = sum;
`ifdef MAC_SEQ_STALL_CNT_EN
      e.stall     = stalls;
`else
      e.stall     = 0;
`endif
      e.pops      = n;
      e.pop_base  = total_pops;
      e.start_cyc = cyc;
      e.lat       = n + stalls + 3;
      if (abort_at == 0) exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      done  = 0;
      while (!done) begin
         if (abort_at > 0 && idx == abort_at) begin
            rst = 1'b1;
            a_valid = 1'b0;
            b_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checkAllZero("abort");
            checkOutput("abort_pops", 64'(total_pops - e.pop_base), 64'(abort_at));
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         if (idx < n) begin
            a_data  = job_a[idx];
            b_data  = job_b[idx];
            a_valid = 1'b1;
            b_valid = 1'b1;
            if (hold_left > 0) begin
               if (mode == 1) b_valid = 1'b0;
               else begin
                  case ($urandom_range(2))
                     0: begin a_valid = 1'b0; b_valid = 1'b0; end
                     1: a_valid = 1'b0;
                     default: b_valid = 1'b0;
                  endcase
               end
               hold_left--;
            end
         end else begin
            a_valid = 1'b0;
            b_valid = 1'b0;
            a_data  = '0;
            b_data  = '0;
         end
         @(negedge clk);
         fired = a_ready && a_valid;
         done  = res_valid;
         @(posedge clk); #1;
         if (fired) begin
            idx++;
            if (idx < n) hold_left = stall_before[idx];
         end
         guard++;
         if (guard > budget) begin
            checkOutput("timeout_res_valid", 0, 1);
            return;
         end
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int k = 0; k < ready_delay; k++) begin
         if (start_in_wait && k == 1) begin
            start = 1'b1;
            len   = LW'(7);
         end
         @(negedge clk);
         checkOutput("wait_res_data", 64'(res_data), 64'(sum));
         checkOutput("wait_busy_valid", 64'({busy, res_valid}), 64'(3));
         @(posedge clk); #1;
         start = 1'b0;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      checkOutput("post_handshake_idle", 64'({busy, res_valid}), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0;
      a_data = '0; b_data = '0; a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkAllZero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin job_a[i] = DW'(i + 1); job_b[i] = DW'(i + 5); end
      applyStimulus(4, 0, 0, 0, 0);
      applyStimulus(4, 1, 0, 0, 0);

      applyStimulus(0, 0, 0, 0, 0);
      job_a[0] = 8'd255; job_b[0] = 8'd255;
      applyStimulus(1, 0, 0, 0, 0);

      for (int i = 0; i < 3; i++) begin job_a[i] = DW'($urandom); job_b[i] = DW'($urandom); end
      applyStimulus(3, 0, 5, 1, 0);

      for (int i = 0; i < 4; i++) begin job_a[i] = DW'($urandom); job_b[i] = DW'($urandom); end
      applyStimulus(4, 0, 0, 0, 2);
      for (int i = 0; i < 2; i++) begin job_a[i] = 8'd3; job_b[i] = 8'd3; end
      applyStimulus(2, 0, 0, 0, 0);

      for (int i = 0; i < 255; i++) begin job_a[i] = 8'd255; job_b[i] = 8'd255; end
      applyStimulus(255, 0, 0, 0, 0);

      for (int j = 0; j < 6; j++) begin
         int n;
         n = $urandom_range(12, 1);
         for (int i = 0; i < n; i++) begin job_a[i] = DW'($urandom); job_b[i] = DW'($urandom); end
         applyStimulus(n, 2, $urandom_range(3), 0, 0);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("scoreboard_empty", 64'(exp_q.size()), 0);
      checkOutput("protocol_errors", 64'(proto_err), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mac_seq.md
# mac_seq

Sequencer that drives one MAC accumulator as its initiator: on a start command it clears the MAC, pops `len` operand pairs from two valid/ready streams, drives them onto the MAC's enable and operand inputs, then returns the accumulated sum on a valid/ready result port. It sits between the operand FIFOs and the MAC in the matrix-vector datapath; the parent instantiates one `mac_seq` per MAC.

## Interface
- `DATA_WIDTH`, 8, operand width; result width is `3*DATA_WIDTH`.
- `LEN_W`, 8, width of the length field; max vector length is `2**LEN_W-1`.
- `STALL_W`, 16, width of the stall counter.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  start pulse; sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs; latched with `start`.
- `busy`  out  1  high in any state other than IDLE.
- `a_data`, `b_data`  in  DATA_WIDTH  operand streams.
- `a_valid`, `b_valid`  in  1  operand valid.
- `a_ready`, `b_ready`  out  1  operand pop.
- `mac_en`  out  1  MAC enable.
- `mac_clr`  out  1  MAC clear.
- `mac_a`, `mac_b`  out  DATA_WIDTH  MAC operands.
- `mac_cout`  in  3*DATA_WIDTH  MAC accumulator value.
- `res_data`  out  3*DATA_WIDTH  captured result.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result accepted.
- `stall_cnt`  out  STALL_W  RUN cycles with no operand fire.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: `start` latches `len` into `remaining`, goes to CLEAR. `start` is ignored in every other state.
- CLEAR: `mac_clr`=1 for exactly this cycle, `mac_en`=0.
  - If `remaining`==0, go to DRAIN.
  - Otherwise go to RUN.
- RUN:
  - `fire` = `a_valid & b_valid`.
  - `a_ready` = `b_ready` = `fire`, so both streams pop jointly and never singly.
  - `mac_en` = `fire`.
  - `mac_a`/`mac_b` = `a_data`/`b_data`, combinational pass-through.
  - On `fire`, `remaining` decrements; a fire with `remaining`==1 goes to DRAIN.
- DRAIN: one cycle with `mac_en`=0. `res_data` <= `mac_cout` at the end of this cycle, then go to DONE.
- DONE:
  - `res_valid`=1 and `res_data` is held stable until `res_ready`.
  - `res_valid & res_ready` goes to IDLE.
  - The MAC is not cleared here; it holds its sum until the next CLEAR.
- Outside RUN: `a_ready`, `b_ready` and `mac_en` are 0, and `mac_a`/`mac_b` are 0.
- Arithmetic is done in the MAC (product plus accumulator, modulo `2**(3*DATA_WIDTH)`). `mac_seq` does no arithmetic on data.

## Timing
- Reset values: state IDLE, and every output 0 (`busy`, `a_ready`, `b_ready`, `mac_en`, `mac_clr`, `mac_a`, `mac_b`, `res_data`, `res_valid`, `stall_cnt`).
- Reset mid-operation: returns to IDLE next cycle. No further operands are popped and no result is produced. The MAC's own state is recovered by the next CLEAR.
- Latency with operands always valid: `start` in cycle 0, CLEAR in cycle 1, RUN in cycles 2..N+1, DRAIN in cycle N+2, `res_valid` high from cycle N+3.
- `len`=0: CLEAR, DRAIN, then DONE with `res_data`=0 and `res_valid` in cycle 3. No operands are popped.
- The MAC registers on En with a 1-cycle latency. DRAIN exists so that `mac_cout` includes the last product before capture.
- Back-to-back: the earliest new `start` is accepted the cycle after the `res_valid & res_ready` handshake.

## Configuration
- `MAC_SEQ_STALL_CNT_EN` defined:
  - `stall_cnt` counts RUN cycles with `fire`=0.
  - It is cleared when `start` is accepted and saturates at all-ones.
  - It holds its value after RUN until the next start.
- `MAC_SEQ_STALL_CNT_EN` not defined: `stall_cnt` is tied to 0 and no counter logic is built.

## Structure
- Package `mac_seq_pkg` holds:
  - the state enum `mac_seq_state_t`;
  - the localparam function `acc_w(DATA_WIDTH)` = `3*DATA_WIDTH`, shared with the MAC's width.
- No sub-module. The MAC is a sibling instantiated by the parent, and `mac_seq` connects only through its `mac_*` ports.

## Test plan
- Pair `mac_seq` with the MAC, DATA_WIDTH=8, `len`=4, A={1,2,3,4}, B={5,6,7,8}, always valid -> `res_data`=70, `res_valid` rises in cycle 7 after `start`, exactly 4 pops per stream.
- Same job with `b_valid` low for 3 cycles mid-run -> `res_data`=70, no single-stream pops, `stall_cnt`=3 with macro defined and 0 without.
- `len`=0 -> `res_data`=0 with `res_valid` in cycle 3 and `a_ready`/`b_ready` never high. Then a second job with `len`=1, A=255, B=255 -> `res_data`=65025, proving the clear.
- `res_ready` held low 5 cycles in DONE -> `res_data` stable, `busy`=1, and a `start` pulse during the wait is ignored.
- `rst` asserted in RUN after 2 of 4 pops -> next cycle all outputs are 0 and state is IDLE. A new job with `len`=2, A={3,3}, B={3,3} -> `res_data`=18.
- Max length `len`=255, A=B=255 every pair -> `res_data`=255·65025=16581375, which fits in 24 bits.
